encoder_4_2_seq: RTL

Registered 4-to-2 encoder: the encoding counterpart of the team's 2-to-4 decoder. Captures a 4-bit request vector into a sticky pending register, then presents one pending request at a time as a 2-bit index under a valid/ready handshake. Sits between request sources (buttons, status lines) and any consumer that drives the decoder with the returned index.

---
 rtl/encoder_4_2_seq_if.sv | 29 ++
 rtl/encoder_4_2_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/encoder_4_2_seq_if.sv
// Request/index bus for encoder_4_2_seq: request lines in, one encoded index out
// under valid/ready, plus the visible pending set and the merge-drop pulse.
interface encoder_4_2_seq_if;
  logic [3:0] d_i;
  logic [1:0] a_o;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] pending_o;
  logic       drop_o;

  // The encoder itself is the slave; the request source/consumer side is the master.
  modport slave (
    input  d_i,
    input  ready_i,
    output a_o,
    output valid_o,
    output pending_o,
    output drop_o
  );

  modport master (
    output d_i,
    output ready_i,
    input  a_o,
    input  valid_o,
    input  pending_o,
    input  drop_o
  );
endinterface

// File: rtl/encoder_4_2_seq.sv
// Registered 4-to-2 encoder with a sticky pending set and a valid/ready output slot.
// Optional macro ENCODER_ROUND_ROBIN_EN selects rotating priority instead of fixed (bit 3 highest).
module encoder_4_2_seq (
  input logic                clk_i,
  input logic                rst_ni,
  encoder_4_2_seq_if.slave   bus
);

  logic [3:0] pending_q, pending_d;
  logic [1:0] a_q, a_d;
  logic       valid_q, valid_d;
  logic       drop_q, drop_d;
  logic       slotFree;
  logic [3:0] pick;

  function automatic logic [1:0] encodeOneHot(input logic [3:0] oneHot);
    logic [1:0] idx;
    idx = 2'b00;
    unique case (oneHot)
      4'b0010: idx = 2'b01;
      4'b0100: idx = 2'b10;
      4'b1000: idx = 2'b11;
      default: idx = 2'b00;
    endcase
    return idx;
  endfunction

  assign slotFree = !valid_q || bus.ready_i;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [1:0] grant_q, grant_d;

  // Search starts just after the last granted index and wraps; reset value 3 makes index 0 first.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = 4'b0000;
    found = 1'b0;
    idx   = 2'b00;
    for (int k = 0; k < 4; k++) begin
      idx = grant_q + 2'(k + 1);
      if (!found && pending_q[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    if (!slotFree) begin
      pick = 4'b0000;
    end
  end

  always_comb begin
    grant_d = grant_q;
    if (slotFree && (pick != 4'b0000)) begin
      grant_d = encodeOneHot(pick);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q <= 2'b11;
    end else begin
      grant_q <= grant_d;
    end
  end
`else
  // Fixed priority; holding all requests high starves the lower bits by design.
  always_comb begin
    pick = 4'b0000;
    if (slotFree) begin
      if (pending_q[3])      pick = 4'b1000;
      else if (pending_q[2]) pick = 4'b0100;
      else if (pending_q[1]) pick = 4'b0010;
      else if (pending_q[0]) pick = 4'b0001;
    end
  end
`endif

  // Fresh requests always land in the pending set, even on the bit being picked this edge.
  always_comb begin
    pending_d = (pending_q & ~pick) | bus.d_i;
    drop_d    = |(bus.d_i & pending_q & ~pick);
    valid_d   = valid_q;
    a_d       = a_q;
    if (slotFree) begin
      if (pick != 4'b0000) begin
        valid_d = 1'b1;
        a_d     = encodeOneHot(pick);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 4'b0000;
      a_q       <= 2'b00;
      valid_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      a_q       <= a_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.a_o       = a_q;
  assign bus.valid_o   = valid_q;
  assign bus.pending_o = pending_q;
  assign bus.drop_o    = drop_q;

endmodule
